// File: rtl/bcd_counter_4dig_pkg.sv
// Shared BCD types, digit limits and digit sanitising used by the counter and decoder stages.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_MIN = 4'd0;

    // Codes 10..15 are not decimal digits; they collapse to zero.
    function automatic bcd_digit_t bcd_sanitize(input bcd_digit_t d);
        return (d > BCD_MAX) ? BCD_MIN : d;
    endfunction

endpackage

// File: rtl/bcd_counter_4dig_if.sv
// Control/status bundle between the switch/display logic (master) and the BCD counter (slave).
interface bcd_counter_4dig_if #(
    parameter int NDIG = 4
);
    logic                EN;
    logic                UP;
    logic                LOAD;
    logic [4*NDIG-1:0]   LOAD_VAL;
    logic [4*NDIG-1:0]   BCD;
    logic                TICK;
    logic                WRAP;

    modport master (
        output EN, UP, LOAD, LOAD_VAL,
        input  BCD, TICK, WRAP
    );

    modport slave (
        input  EN, UP, LOAD, LOAD_VAL,
        output BCD, TICK, WRAP
    );
endinterface

// File: rtl/bcd_counter_4dig_digit.sv
// Single decade up/down cell; carry_out doubles as the borrow when counting down.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  bcd_digit_t load_val,
    input  logic       step,
    input  logic       up,
    output bcd_digit_t q,
    output logic       carry_out
);

    // Combinational so a carry ripples through every decade within the same cycle.
    assign carry_out = step && (up ? (q == BCD_MAX) : (q == BCD_MIN));

    always_ff @(posedge clk) begin
        // NOTE: non-blocking updates make every cell see its neighbours' pre-edge values.
        if (rst) begin
            q <= BCD_MIN;
        end else if (load) begin
            q <= bcd_sanitize(load_val);
        end else if (step) begin
            if (up) begin
                q <= (q == BCD_MAX) ? BCD_MIN : q + 4'd1;
            end else begin
                q <= (q == BCD_MIN) ? BCD_MAX : q - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_counter_4dig.sv
// Four-digit BCD up/down counter with prescaler, load and wrap flag.
// Define BCD_COUNTER_SATURATE_EN to hold at 9999/0000 instead of wrapping.
module bcd_counter_4dig
    import bcd_pkg::*;
#(
    parameter int PRESCALE = 50000000,
    parameter int NDIG     = 4
) (
    input  logic              CLOCK_50,
    input  logic              RESET,
    bcd_counter_4dig_if.slave bus
);

    localparam int PW = $clog2(PRESCALE);

    logic [PW-1:0]      pcnt;
    logic               tick;
    logic               count_en;
    logic               step_units;
    logic [NDIG:0]      carry;
    logic [4*NDIG-1:0]  bcd;

    assign tick = (pcnt == PW'(PRESCALE - 1));

    // Free-running: only reset touches the prescaler.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            pcnt <= '0;
        end else if (tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PW'(1);
        end
    end

    assign count_en = tick & bus.EN & ~bus.LOAD;

`ifdef BCD_COUNTER_SATURATE_EN
    logic at_limit;

    assign at_limit   = bus.UP ? (bcd == {NDIG{BCD_MAX}}) : (bcd == {NDIG{BCD_MIN}});
    assign step_units = count_en & ~at_limit;
    assign bus.WRAP   = 1'b0;
`else
    logic wrap_q;

    assign step_units = count_en;

    // Carry out of the top decade is exactly the 9999<->0000 rollover.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= carry[NDIG];
        end
    end

    assign bus.WRAP = wrap_q;
`endif

    assign carry[0] = step_units;

    for (genvar i = 0; i < NDIG; i++) begin : g_digit
        bcd_digit u_digit (
            .clk       (CLOCK_50),
            .rst       (RESET),
            .load      (bus.LOAD),
            .load_val  (bus.LOAD_VAL[4*i +: 4]),
            .step      (carry[i]),
            .up        (bus.UP),
            .q         (bcd[4*i +: 4]),
            .carry_out (carry[i+1])
        );
    end

    assign bus.BCD  = bcd;
    assign bus.TICK = tick;

endmodule

// File: tb/tb_bcd_counter_4dig.sv
// Self-checking bench for bcd_counter_4dig: phase table plus per-cycle integer reference model.
module tb_bcd_counter_4dig;

    localparam int PRESCALE = 4;

`ifdef BCD_COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   tick_cnt;
    int   wrap_cnt;
    bit   armed;

    // Reference model state: count as a plain integer, prescaler phase, wrap flag.
    int   m_cnt;
    int   m_pre;
    bit   m_wrap;

    logic [17:0] exp_q[$];

    typedef struct {
        logic        rst;
        logic        en;
        logic        up;
        logic        load;
        logic [15:0] lv;
        int          ncyc;
        logic [15:0] exp_bcd;
        int          exp_ticks;
        int          exp_wraps;
    } vec_t;

    vec_t vecs[$];

    bcd_counter_4dig_if #(.NDIG(4)) bus ();

    bcd_counter_4dig #(
        .PRESCALE (PRESCALE),
        .NDIG     (4)
    ) dut (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int          t;
        t = v;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int sanitize_val(input logic [15:0] lv);
        int v;
        int w;
        int d;
        v = 0;
        w = 1;
        for (int i = 0; i < 4; i++) begin
            d = int'(lv[4*i +: 4]);
            if (d > 9) d = 0;
            v = v + d * w;
            w = w * 10;
        end
        return v;
    endfunction

    function automatic bit digits_ok(input logic [15:0] b);
        for (int i = 0; i < 4; i++) begin
            if (b[4*i +: 4] > 4'd9) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, push expectation, compare after the edge.
    task automatic cyc(input logic r, input logic e, input logic u, input logic l,
                       input logic [15:0] lv);
        bit          tick_now;
        logic [17:0] got;
        rst          = r;
        bus.EN       = e;
        bus.UP       = u;
        bus.LOAD     = l;
        bus.LOAD_VAL = lv;

        tick_now = (m_pre == PRESCALE - 1);
        if (r) begin
            m_cnt  = 0;
            m_pre  = 0;
            m_wrap = 1'b0;
        end else begin
            m_pre  = tick_now ? 0 : m_pre + 1;
            m_wrap = 1'b0;
            if (l) begin
                m_cnt = sanitize_val(lv);
            end else if (tick_now && e) begin
                if (u) begin
                    if (m_cnt == 9999) begin
                        if (!SAT) begin
                            m_cnt  = 0;
                            m_wrap = 1'b1;
                        end
                    end else begin
                        m_cnt = m_cnt + 1;
                    end
                end else begin
                    if (m_cnt == 0) begin
                        if (!SAT) begin
                            m_cnt  = 9999;
                            m_wrap = 1'b1;
                        end
                    end else begin
                        m_cnt = m_cnt - 1;
                    end
                end
            end
        end
        exp_q.push_back({to_bcd(m_cnt), (m_pre == PRESCALE - 1), m_wrap});

        @(posedge clk);
        #1;
        got = {bus.BCD, bus.TICK, bus.WRAP};
        check("scoreboard_bcd_tick_wrap", 32'(got), 32'(exp_q.pop_front()));
        if (bus.TICK) tick_cnt++;
        if (bus.WRAP) wrap_cnt++;
    endtask

    always @(negedge clk) begin
        if (armed) begin
            checks++;
            assert (digits_ok(bus.BCD)) else begin
                errors++;
                $display("FAIL digit_range bcd=%h", bus.BCD);
            end
        end
    end

    initial begin
        checks       = 0;
        errors       = 0;
        armed        = 1'b0;
        m_cnt        = 0;
        m_pre        = 0;
        m_wrap       = 1'b0;
        rst          = 1'b1;
        bus.EN       = 1'b0;
        bus.UP       = 1'b1;
        bus.LOAD     = 1'b0;
        bus.LOAD_VAL = '0;

        //                rst  en   up   load lv        ncyc bcd                        ticks wraps
        vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 16'h0000,  2, 16'h0000,                  0, 0});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 48, 16'h0012,                 12, 0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 40, 16'h0012,                 10, 0});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 16'hA5F3,  4, 16'h0503,                  1, 0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000,  4, 16'h0502,                  1, 0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 16'h1000,  4, 16'h1000,                  1, 0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000,  4, 16'h0999,                  1, 0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 16'h9998,  4, 16'h9998,                  1, 0});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000,  4, 16'h9999,                  1, 0});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000,  4, SAT ? 16'h9999 : 16'h0000, 1, SAT ? 0 : 1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000,  4, 16'h0000,                  1, 0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000,  4, SAT ? 16'h0000 : 16'h9999, 1, SAT ? 0 : 1});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 16'h0457,  4, 16'h0457,                  1, 0});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000,  6, 16'h0458,                  1, 0});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 16'h0000,  1, 16'h0000,                  0, 0});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000,  3, 16'h0000,                  1, 0});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000,  1, 16'h0001,                  0, 0});

        #2;
        foreach (vecs[k]) begin
            tick_cnt = 0;
            wrap_cnt = 0;
            for (int n = 0; n < vecs[k].ncyc; n++) begin
                cyc(vecs[k].rst, vecs[k].en, vecs[k].up, vecs[k].load, vecs[k].lv);
                armed = 1'b1;
            end
            check($sformatf("vec%0d_bcd", k), 32'(bus.BCD), 32'(vecs[k].exp_bcd));
            check($sformatf("vec%0d_ticks", k), tick_cnt, vecs[k].exp_ticks);
            check($sformatf("vec%0d_wraps", k), wrap_cnt, vecs[k].exp_wraps);
        end

        // Random traffic, biased towards loads near the rollover points.
        for (int n = 0; n < 10000; n++) begin
            logic        r;
            logic        l;
            logic [15:0] lv;
            r = ($urandom_range(0, 499) == 0);
            l = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 3))
                0:       lv = 16'h9999;
                1:       lv = 16'h0000;
                default: lv = 16'($urandom);
            endcase
            cyc(r, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), l, lv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
